// File: rtl/pcpi_dispatch_if.sv
// Bus bundle between the CPU PCPI port, the dispatcher and the two coprocessor cores.
// The dispatcher takes the slave view; the environment (CPU + cores) takes the master view.
interface pcpi_dispatch_if;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_ready;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;

  logic        a_valid;
  logic [31:0] a_insn;
  logic [31:0] a_rs1;
  logic [31:0] a_rs2;
  logic        a_ready;
  logic [31:0] a_rd;
  logic        a_wr;

  logic        b_valid;
  logic [31:0] b_insn;
  logic [31:0] b_rs1;
  logic [31:0] b_rs2;
  logic        b_ready;
  logic [31:0] b_rd;
  logic        b_wr;

  modport slave (
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    output pcpi_ready, pcpi_wr, pcpi_rd, pcpi_wait,
    output a_valid, a_insn, a_rs1, a_rs2,
    input  a_ready, a_rd, a_wr,
    output b_valid, b_insn, b_rs1, b_rs2,
    input  b_ready, b_rd, b_wr
  );

  modport master (
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    input  pcpi_ready, pcpi_wr, pcpi_rd, pcpi_wait,
    input  a_valid, a_insn, a_rs1, a_rs2,
    output a_ready, a_rd, a_wr,
    input  b_valid, b_insn, b_rs1, b_rs2,
    output b_ready, b_rd, b_wr
  );
endinterface

// File: rtl/pcpi_dispatch.sv
// Routes claimed PCPI instructions to core A (funct3[2]=0) or core B (funct3[2]=1) with a WAIT timeout.
// Define PCPI_DISPATCH_STATS_EN to add the cnt_a / cnt_b / cnt_abort statistics outputs.
module pcpi_dispatch #(
  parameter int unsigned TIMEOUT = 64,
  parameter logic [6:0]  FUNCT7  = 7'b0000001
) (
  input  logic           clk,
  input  logic           reset,
  pcpi_dispatch_if.slave bus,
  output logic           err_timeout
`ifdef PCPI_DISPATCH_STATS_EN
  ,
  output logic [15:0]    cnt_a,
  output logic [15:0]    cnt_b,
  output logic [7:0]     cnt_abort
`endif
);
  localparam int unsigned DATA_W   = 32;
  localparam logic [6:0]  OPCODE   = 7'b0110011;
  localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_ABORT} state_t;

  state_t            state;
  logic              blk;
  logic              tgt_b;
  logic [7:0]        tmo_cnt;
  logic [DATA_W-1:0] insn_q, rs1_q, rs2_q, rd_q;
  logic              ready_q, wr_q, wait_q, a_valid_q, b_valid_q, err_q;

  logic              match;
  logic              tgt_ready;
  logic              tgt_wr;
  logic [DATA_W-1:0] tgt_rd;

  assign match     = (bus.pcpi_insn[6:0] == OPCODE) && (bus.pcpi_insn[31:25] == FUNCT7);
  assign tgt_ready = tgt_b ? bus.b_ready : bus.a_ready;
  assign tgt_rd    = tgt_b ? bus.b_rd    : bus.a_rd;
  assign tgt_wr    = tgt_b ? bus.b_wr    : bus.a_wr;

`ifdef PCPI_DISPATCH_STATS_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
`endif

  // blk suppresses the accept in the IDLE cycle that follows DONE, while the CPU still holds pcpi_valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      blk       <= 1'b0;
      tgt_b     <= 1'b0;
      tmo_cnt   <= '0;
      insn_q    <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      ready_q   <= 1'b0;
      wr_q      <= 1'b0;
      wait_q    <= 1'b0;
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      err_q     <= 1'b0;
`ifdef PCPI_DISPATCH_STATS_EN
      cnt_a     <= '0;
      cnt_b     <= '0;
      cnt_abort <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          blk <= 1'b0;
          if (bus.pcpi_valid && match && !blk) begin
            insn_q    <= bus.pcpi_insn;
            rs1_q     <= bus.pcpi_rs1;
            rs2_q     <= bus.pcpi_rs2;
            tgt_b     <= bus.pcpi_insn[14];
            a_valid_q <= !bus.pcpi_insn[14];
            b_valid_q <= bus.pcpi_insn[14];
            wait_q    <= 1'b1;
            state     <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (!bus.pcpi_valid) begin
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
            wait_q    <= 1'b0;
            insn_q    <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            state     <= S_IDLE;
          end else begin
            tmo_cnt <= '0;
            state   <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (!bus.pcpi_valid || tgt_ready || (tmo_cnt == TMO_LAST)) begin
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
            wait_q    <= 1'b0;
            insn_q    <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
          end
          // a CPU abandon wins over everything; a ready in the timeout cycle still completes
          if (!bus.pcpi_valid) begin
            state <= S_IDLE;
          end else if (tgt_ready) begin
            rd_q    <= tgt_rd;
            wr_q    <= tgt_wr;
            ready_q <= 1'b1;
            state   <= S_DONE;
`ifdef PCPI_DISPATCH_STATS_EN
            if (tgt_b) cnt_b <= cnt_b + 16'd1;
            else       cnt_a <= cnt_a + 16'd1;
`endif
          end else if (tmo_cnt == TMO_LAST) begin
            err_q <= 1'b1;
            state <= S_ABORT;
`ifdef PCPI_DISPATCH_STATS_EN
            cnt_abort <= sat_inc8(cnt_abort);
`endif
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        S_DONE: begin
          ready_q <= 1'b0;
          rd_q    <= '0;
          wr_q    <= 1'b0;
          blk     <= 1'b1;
          state   <= S_IDLE;
        end

        S_ABORT: begin
          if (!bus.pcpi_valid) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.pcpi_ready = ready_q;
  assign bus.pcpi_wr    = wr_q;
  assign bus.pcpi_rd    = rd_q;
  assign bus.pcpi_wait  = wait_q;
  assign bus.a_valid    = a_valid_q;
  assign bus.a_insn     = insn_q;
  assign bus.a_rs1      = rs1_q;
  assign bus.a_rs2      = rs2_q;
  assign bus.b_valid    = b_valid_q;
  assign bus.b_insn     = insn_q;
  assign bus.b_rs1      = rs1_q;
  assign bus.b_rs2      = rs2_q;
  assign err_timeout    = err_q;
endmodule

// File: tb/tb_pcpi_dispatch.sv
// Bench for pcpi_dispatch: plays the CPU and both coprocessor cores, checks against a transaction-level model.
`timescale 1ns/1ps
module tb_pcpi_dispatch;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic reset;
  logic err_timeout;
`ifdef PCPI_DISPATCH_STATS_EN
  logic [15:0] cnt_a, cnt_b;
  logic [7:0]  cnt_abort;
`endif

  pcpi_dispatch_if bus();

  pcpi_dispatch #(.TIMEOUT(TMO), .FUNCT7(7'b0000001)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .err_timeout (err_timeout)
`ifdef PCPI_DISPATCH_STATS_EN
    ,
    .cnt_a       (cnt_a),
    .cnt_b       (cnt_b),
    .cnt_abort   (cnt_abort)
`endif
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  bit          err_m;
  logic [15:0] exp_a, exp_b;
  logic [7:0]  exp_ab;
  int          lead;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    err_m  = 1'b0;
    exp_a  = '0;
    exp_b  = '0;
    exp_ab = '0;
  endtask

  function automatic bit is_match(input logic [31:0] insn);
    return (insn[6:0] == 7'b0110011) && (insn[31:25] == 7'b0000001);
  endfunction

  // What the external cores compute; the dispatcher only routes the answer
  function automatic logic [31:0] core_fn(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2);
    case (insn[14:12])
      3'd0:    return rs1 * rs2;
      3'd4:    return (rs2 == 0) ? 32'hFFFF_FFFF : rs1 / rs2;
      default: return rs1 ^ rs2 ^ insn;
    endcase
  endfunction

  // Offer one instruction at the current negedge. lead = idle cycles the dispatcher needs before it
  // can accept; the target core answers `delay` cycles after it first sees its valid.
  task automatic run_txn(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2,
                         input int delay, input int lead_in, input bit hold, output int lead_out);
    bit          m, tb, done, abort, busy;
    int          e, n, seen, rdy_cnt, rdy_at, bad_wait, bad_tv, bad_ov, bad_fld;
    logic        tv, ov, fire, wr_got, exp_wr;
    logic [31:0] rd_got, exp_rd;
    m      = is_match(insn);
    tb     = insn[14];
    done   = m && (delay <= TMO);
    abort  = m && !done;
    e      = done ? lead_in + delay + 2 : (abort ? lead_in + TMO + 2 : 0);
    n      = m ? e : lead_in + 20;
    exp_rd = core_fn(insn, rs1, rs2);
    exp_wr = (insn[11:7] != 5'd0);
    seen = 0; rdy_cnt = 0; rdy_at = -1; bad_wait = 0; bad_tv = 0; bad_ov = 0; bad_fld = 0;
    rd_got = '0; wr_got = 1'b0;
    bus.pcpi_valid = 1'b1;
    bus.pcpi_insn  = insn;
    bus.pcpi_rs1   = rs1;
    bus.pcpi_rs2   = rs2;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      tv   = tb ? bus.b_valid : bus.a_valid;
      ov   = tb ? bus.a_valid : bus.b_valid;
      busy = m && (i > lead_in) && (i < e);
      if (bus.pcpi_wait !== busy) bad_wait++;
      if (tv !== busy) bad_tv++;
      if (ov !== 1'b0) bad_ov++;
      if (tv === 1'b1 && (bus.a_insn !== insn || bus.a_rs1 !== rs1 || bus.a_rs2 !== rs2 ||
                          bus.b_insn !== insn || bus.b_rs1 !== rs1 || bus.b_rs2 !== rs2)) bad_fld++;
      if (bus.pcpi_ready === 1'b1) begin
        rdy_cnt++;
        rdy_at = i;
        rd_got = bus.pcpi_rd;
        wr_got = bus.pcpi_wr;
      end
      if (tv === 1'b1) seen++;
      fire = m && (tv === 1'b1) && (seen == delay + 1);
      if (tb) begin
        bus.b_ready = fire;  bus.b_rd = fire ? exp_rd : $urandom;  bus.b_wr = fire ? exp_wr : 1'($urandom);
        bus.a_ready = 1'($urandom); bus.a_rd = $urandom; bus.a_wr = 1'($urandom);
      end else begin
        bus.a_ready = fire;  bus.a_rd = fire ? exp_rd : $urandom;  bus.a_wr = fire ? exp_wr : 1'($urandom);
        bus.b_ready = 1'($urandom); bus.b_rd = $urandom; bus.b_wr = 1'($urandom);
      end
    end
    bus.a_ready = 1'b0;
    bus.b_ready = 1'b0;
    if (!hold) begin
      bus.pcpi_valid = 1'b0;
      @(negedge clk);
      if (bus.pcpi_ready === 1'b1) rdy_cnt++;
      if (bus.pcpi_wait !== 1'b0 || bus.a_valid !== 1'b0 || bus.b_valid !== 1'b0) bad_wait++;
    end
    if (done) begin
      if (tb) exp_b = exp_b + 16'd1;
      else    exp_a = exp_a + 16'd1;
    end
    if (abort) begin
      err_m = 1'b1;
      if (exp_ab != 8'hFF) exp_ab = exp_ab + 8'd1;
    end
    check("ready_pulses", 64'(rdy_cnt), done ? 64'd1 : 64'd0);
    if (done) begin
      check("ready_cycle", 64'(rdy_at), 64'(e));
      check("pcpi_rd", 64'(rd_got), 64'(exp_rd));
      check("pcpi_wr", 64'(wr_got), 64'(exp_wr));
    end
    check("wait_pattern_errs", 64'(bad_wait), 64'd0);
    check("target_valid_errs", 64'(bad_tv), 64'd0);
    check("other_valid_errs", 64'(bad_ov), 64'd0);
    check("latched_field_errs", 64'(bad_fld), 64'd0);
    check("err_timeout", 64'(err_timeout), 64'(err_m));
    lead_out = done ? (hold ? 2 : 1) : 0;
  endtask

  initial begin
    logic [31:0] insn;
    int          delay;
    bit          hold;

    reset = 1'b0;
    bus.pcpi_valid = 1'b0; bus.pcpi_insn = '0; bus.pcpi_rs1 = '0; bus.pcpi_rs2 = '0;
    bus.a_ready = 1'b0; bus.a_rd = '0; bus.a_wr = 1'b0;
    bus.b_ready = 1'b0; bus.b_rd = '0; bus.b_wr = 1'b0;
    model_reset();

    // reset state
    #1 reset = 1'b1;
    #1;
    check("rst_pcpi_ready", 64'(bus.pcpi_ready), 64'd0);
    check("rst_pcpi_wait", 64'(bus.pcpi_wait), 64'd0);
    check("rst_pcpi_rd", 64'(bus.pcpi_rd), 64'd0);
    check("rst_valids", 64'({bus.a_valid, bus.b_valid}), 64'd0);
    check("rst_fields", 64'(bus.a_insn | bus.a_rs1 | bus.b_rs2), 64'd0);
    check("rst_err", 64'(err_timeout), 64'd0);
`ifdef PCPI_DISPATCH_STATS_EN
    check("rst_stats", 64'({cnt_a, cnt_b, cnt_abort}), 64'd0);
`endif
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // MUL to core A, 4-cycle core
    run_txn(32'h02B5_0533, 32'd7, 32'd6, 4, 0, 1'b0, lead);
    // DIV to core B, 1-cycle core: ready 3 cycles after valid
    repeat (lead) @(negedge clk);
    run_txn(32'h02B5_4533, 32'd100, 32'd7, 1, 0, 1'b0, lead);
    // ADD is not claimed
    run_txn(32'h00B5_0533, 32'd1, 32'd2, 1, lead, 1'b0, lead);

    // core A never answers: abort, then late readies are ignored
    run_txn(32'h02B5_0533, 32'd3, 32'd4, 1000, lead, 1'b1, lead);
    bus.a_ready = 1'b1; bus.a_rd = 32'hDEAD_BEEF; bus.a_wr = 1'b1;
    @(negedge clk);
    bus.a_ready = 1'b0;
    check("abort_late_ready", 64'(bus.pcpi_ready), 64'd0);
    check("abort_wait", 64'(bus.pcpi_wait), 64'd0);
    check("abort_a_valid", 64'(bus.a_valid), 64'd0);
    check("abort_err_set", 64'(err_timeout), 64'd1);
    bus.pcpi_valid = 1'b0;
    @(negedge clk);
    bus.a_ready = 1'b1;
    @(negedge clk);
    bus.a_ready = 1'b0;
    check("idle_late_ready", 64'(bus.pcpi_ready), 64'd0);

    // CPU withdraws pcpi_valid in WAIT
    bus.pcpi_valid = 1'b1; bus.pcpi_insn = 32'h02C6_8733; bus.pcpi_rs1 = 32'd5; bus.pcpi_rs2 = 32'd9;
    repeat (4) @(negedge clk);
    check("drop_wait_before", 64'(bus.pcpi_wait), 64'd1);
    bus.pcpi_valid = 1'b0;
    @(negedge clk);
    check("drop_outputs", 64'({bus.a_valid, bus.b_valid, bus.pcpi_wait}), 64'd0);
    bus.a_ready = 1'b1; bus.a_rd = 32'd45;
    @(negedge clk);
    bus.a_ready = 1'b0;
    check("drop_no_ready0", 64'(bus.pcpi_ready), 64'd0);
    @(negedge clk);
    check("drop_no_ready1", 64'(bus.pcpi_ready), 64'd0);
    check("drop_err_kept", 64'(err_timeout), 64'(err_m));

    // asynchronous reset in WAIT, then a fresh MUL 3*5
    bus.pcpi_valid = 1'b1; bus.pcpi_insn = 32'h02B5_0533; bus.pcpi_rs1 = 32'd11; bus.pcpi_rs2 = 32'd12;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_wait", 64'(bus.pcpi_wait), 64'd0);
    check("arst_a_valid", 64'(bus.a_valid), 64'd0);
    check("arst_fields", 64'(bus.a_insn), 64'd0);
    check("arst_err", 64'(err_timeout), 64'd0);
    model_reset();
    bus.pcpi_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    run_txn(32'h02B5_0533, 32'd3, 32'd5, 2, 0, 1'b0, lead);

    // back-to-back: 3 MUL then 2 DIV with valid re-asserted at once
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    lead = 0;
    for (int k = 0; k < 5; k++) begin
      insn = (k < 3) ? 32'h02B5_0533 : 32'h02B5_4533;
      run_txn(insn, $urandom, $urandom_range(1, 1000), $urandom_range(1, 5), lead, k < 4, lead);
    end
`ifdef PCPI_DISPATCH_STATS_EN
    check("b2b_cnt_a", 64'(cnt_a), 64'(exp_a));
    check("b2b_cnt_b", 64'(cnt_b), 64'(exp_b));
    check("b2b_cnt_abort", 64'(cnt_abort), 64'(exp_ab));
`endif

    // randomized traffic
    for (int k = 0; k < 40; k++) begin
      insn = $urandom;
      case ($urandom_range(0, 9))
        7:       begin insn[6:0] = 7'b0110011; insn[31:25] = 7'b0000000; end
        8, 9:    insn[6:0] = 7'b0010011;
        default: begin insn[6:0] = 7'b0110011; insn[31:25] = 7'b0000001; end
      endcase
      delay = $urandom_range(1, TMO + 2);
      hold  = ($urandom_range(0, 1) == 1) && !(is_match(insn) && delay > TMO);
      run_txn(insn, $urandom, $urandom, delay, lead, hold, lead);
    end
    bus.pcpi_valid = 1'b0;
    @(negedge clk);
    check("final_err", 64'(err_timeout), 64'(err_m));
`ifdef PCPI_DISPATCH_STATS_EN
    check("final_cnt_a", 64'(cnt_a), 64'(exp_a));
    check("final_cnt_b", 64'(cnt_b), 64'(exp_b));
    check("final_cnt_abort", 64'(cnt_abort), 64'(exp_ab));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pcpi_dispatch.md
# pcpi_dispatch

Sequencer and router between the picorv32 PCPI port and two external coprocessor cores. It owns the CPU-side PCPI handshake and decodes each offered instruction. Matching instructions go to core A (multiply group) or core B (divide group). Each transaction is registered, the target core is sequenced through issue/wait/complete, and hung cores are bounded with a timeout. The block sits in the SoC top between `picorv32` (ENABLE_PCPI=1) and the `ext_pcpi_core` instances.

## Interface
Parameters:
- TIMEOUT, 64: cycles allowed in WAIT before abort; legal range 2..255; counter is 8 bits.
- FUNCT7, 7'b0000001: funct7 value claimed by the dispatcher (opcode fixed at 7'b0110011).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- pcpi_valid  in  1  CPU offers an instruction.
- pcpi_insn  in  32  offered instruction word.
- pcpi_rs1, pcpi_rs2  in  32 each  operands.
- pcpi_ready  out  1  one-cycle completion pulse to CPU.
- pcpi_wr  out  1  write rd, valid with pcpi_ready.
- pcpi_rd  out  32  result, valid with pcpi_ready.
- pcpi_wait  out  1  claim/hold of the current instruction.
- a_valid, b_valid  out  1 each  request to core A / core B.
- a_insn, a_rs1, a_rs2, b_insn, b_rs1, b_rs2  out  32 each  latched request fields.
- a_ready, b_ready  in  1 each  core completion pulse.
- a_rd, b_rd  in  32 each  core result.
- a_wr, b_wr  in  1 each  core write-enable.
- err_timeout  out  1  sticky, set on any abort.

## Operation
- Match: pcpi_insn[6:0]==7'b0110011 and pcpi_insn[31:25]==FUNCT7. Target is core A when insn[14]==0, core B when insn[14]==1.
- States: IDLE, ISSUE, WAIT, DONE, ABORT.
- IDLE: pcpi_valid && match → latch insn, rs1, rs2 and target; go to ISSUE. A non-match stays in IDLE with all outputs low, so the CPU handles the instruction or traps it.
- ISSUE: assert pcpi_wait and the target's x_valid; go to WAIT.
- WAIT: hold x_valid, pcpi_wait and the latched fields stable.
  - x_ready → capture x_rd and x_wr, drop x_valid, go to DONE.
  - Readiness from the non-target core is ignored.
- DONE: pcpi_ready=1 for exactly one cycle, with registered pcpi_rd/pcpi_wr; pcpi_wait=0. Next state is a guaranteed IDLE with no new accept that cycle.
- IDLE additionally blocks acceptance in the cycle right after DONE, because CPU pcpi_valid is still high then.
- Timeout: an 8-bit counter clears on entering WAIT and increments each WAIT cycle. When it reaches TIMEOUT-1 with no x_ready:
  - drop x_valid and pcpi_wait;
  - set err_timeout;
  - go to ABORT.
- ABORT: all outputs low except err_timeout. Return to IDLE when pcpi_valid==0.
- A late x_ready arriving in ABORT or IDLE is discarded.
- x_ready in the same cycle as the timeout is treated as completion (ready wins).
- pcpi_valid falling mid-transaction (CPU IRQ/reset) in ISSUE or WAIT:
  - drop x_valid;
  - go to IDLE without a pcpi_ready pulse;
  - err_timeout unchanged.
- err_timeout is cleared only by reset.

## Timing
- Reset (async assert): state=IDLE, counter=0, latched fields=0. All outputs 0, including err_timeout and statistics.
- Accept at edge N (valid seen in IDLE). Then:
  - pcpi_wait=1 and x_valid=1 from N+1;
  - x_ready at edge M → pcpi_ready pulse during cycle M+1.
- Minimum latency from pcpi_valid to pcpi_ready: 3 cycles (core answers in the first WAIT cycle).
- pcpi_wait rises 1 cycle after pcpi_valid, well inside picorv32's 16-cycle claim window.
- All outputs are registered; no combinational path from inputs to outputs.
- Back-to-back instructions: the next accept happens no earlier than 2 cycles after the pcpi_ready pulse.

## Configuration
- PCPI_DISPATCH_STATS_EN defined adds:
  - outputs cnt_a, cnt_b (16 bits each) counting completed DONE transactions per core, wrapping 0xFFFF→0;
  - output cnt_abort (8 bits), saturating at 0xFF.
  - All three reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- MUL to core A: insn 0x02B50533, rs1=7, rs2=6, core A answers after 4 cycles with rd=42, wr=1 → exactly one pcpi_ready, pcpi_rd=42, pcpi_wr=1, b_valid never high.
- DIV to core B: insn 0x02B54533, rs1=100, rs2=7, core B answers in 1 cycle with rd=14 → pcpi_ready 3 cycles after pcpi_valid, pcpi_rd=14.
- Non-match: insn 0x00B50533 (ADD) held 20 cycles → pcpi_wait, pcpi_ready, a_valid and b_valid stay 0.
- Timeout: TIMEOUT=8, core A never answers → a_valid and pcpi_wait drop after the 8th WAIT cycle, err_timeout=1 stays set; a later x_ready is ignored.
- Reset mid-WAIT: assert reset for 1 cycle during WAIT → all outputs 0 immediately (asynchronously). A fresh MUL 3*5 afterwards gives pcpi_rd=15.
- Back-to-back plus stats (PCPI_DISPATCH_STATS_EN): 3 MUL then 2 DIV, CPU re-asserting valid immediately → no double accept after any DONE; cnt_a=3, cnt_b=2, cnt_abort=0.
